// File: rtl/phase_sequencer_pkg.sv
// Shared types and constants for the phase sequencer block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package phase_sequencer_pkg;

  localparam int PHASE_W = 6;
  localparam logic [PHASE_W-1:0] LAST_PHASE = 6'd63;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/phase_sequencer_if.sv
// Handshake and phase-control bundle between the sequencer and its MAC/consumer side.
// Latency: n/a (wires only).
// Backpressure: out_ready from the consumer holds the result; in_ready gates samples.
interface phase_sequencer_if;
  import phase_sequencer_pkg::*;

  logic               clk_enable;
  logic               in_valid;
  logic               in_ready;
  logic [PHASE_W-1:0] current_count;
  logic               busy;
  logic               acc_clear;
  logic               acc_enable;
  logic               out_valid;
  logic               out_ready;

  // Sequencer side.
  modport master (
    input  clk_enable,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output current_count,
    output busy,
    output acc_clear,
    output acc_enable,
    output out_valid
  );

  // Producer/consumer/datapath side.
  modport slave (
    output clk_enable,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  current_count,
    input  busy,
    input  acc_clear,
    input  acc_enable,
    input  out_valid
  );

endinterface

// File: rtl/phase_sequencer_phase_decode.sv
// Decodes first and last phase of a frame, qualified by the phase-advance enable.
// Latency: combinational, zero cycles.
// Backpressure: none; pure decode.
module phase_sequencer_phase_decode
  import phase_sequencer_pkg::*;
(
  input  logic [PHASE_W-1:0] count,
  input  logic               enable,
  output logic               phase_0,
  output logic               phase_63
);

  assign phase_0  = enable & (count == '0);
  assign phase_63 = enable & (count == LAST_PHASE);

endmodule

// File: rtl/phase_sequencer.sv
// Steps a 64-phase MAC frame per accepted sample and hands the result to a consumer.
// Latency: 64 enabled cycles + 1 clk from sample acceptance to out_valid.
// Backpressure: result held in HOLD until out_ready; no sample accepted while RUN or held.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASES = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  phase_sequencer_if.master  seq
);

  // The counter width fixes the frame length; any other phase count cannot be built.
  if (NUM_PHASES != (1 << PHASE_W)) begin : g_num_phases_check
    $error("phase_sequencer: NUM_PHASES must be 64");
  end

  state_t             state;
  state_t             state_next;
  logic [PHASE_W-1:0] count;
  logic [PHASE_W-1:0] count_next;
  logic               armed;
  logic               phase_0;
  logic               phase_63;

  logic in_ready;
  logic busy;
  logic out_valid;
  logic acc_clear;
  logic acc_enable;

  phase_sequencer_phase_decode u_phase_decode (
    .count    (count),
    .enable   (seq.clk_enable),
    .phase_0  (phase_0),
    .phase_63 (phase_63)
  );

  // State, phase counter and the post-reset arm flag (keeps in_ready low until the first edge).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      armed <= 1'b1;
    end
  end

  // Next-state, counter update and handshake/datapath controls.
  always_comb begin
    state_next = state;
    count_next = count;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    acc_clear  = 1'b0;
    acc_enable = 1'b0;
    case (state)
      IDLE: begin
        in_ready   = armed;
        count_next = '0;
        if (seq.in_valid && armed) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy       = 1'b1;
        acc_enable = seq.clk_enable;
        acc_clear  = phase_0;
        if (seq.clk_enable) begin
          // 63 + 1 wraps to 0 in six bits, ready for the next frame.
          count_next = count + PHASE_W'(1);
        end
        if (phase_63) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid  = 1'b1;
        count_next = '0;
        if (seq.out_ready) begin
          // Taking a new sample in the same cycle the result drains avoids an IDLE bubble.
          in_ready   = 1'b1;
          state_next = seq.in_valid ? RUN : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  assign seq.in_ready      = in_ready;
  assign seq.busy          = busy;
  assign seq.out_valid     = out_valid;
  assign seq.acc_clear     = acc_clear;
  assign seq.acc_enable    = acc_enable;
  assign seq.current_count = count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed, table-driven bench for phase_sequencer plus hand-written frame sequences.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low in HOLD.
module tb_phase_sequencer;
  import phase_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  phase_sequencer_if bus ();

  phase_sequencer #(.NUM_PHASES(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .seq     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ce;
    logic        iv;
    logic        ordy;
    logic [10:0] want;
  } vec_t;

  vec_t tbl[8];

  // {in_ready, busy, out_valid, acc_clear, acc_enable, current_count}
  function automatic logic [10:0] pack(input logic rdy, input logic bsy, input logic ov,
                                       input logic clr, input logic en, input logic [5:0] cnt);
    return {rdy, bsy, ov, clr, en, cnt};
  endfunction

  function automatic logic [10:0] observed();
    return {bus.in_ready, bus.busy, bus.out_valid, bus.acc_clear, bus.acc_enable, bus.current_count};
  endfunction

  task automatic check_vec(input string name, input logic [10:0] want);
    logic [10:0] act;
    act = observed();
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: rdy,busy,ov,clr,en=%b cnt=%0d, expected rdy,busy,ov,clr,en=%b cnt=%0d",
               name, act[10:6], act[5:0], want[10:6], want[5:0]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic drive(input logic ce, input logic iv, input logic ordy);
    bus.clk_enable = ce;
    bus.in_valid   = iv;
    bus.out_ready  = ordy;
  endtask

  // Runs a frame from RUN at phase start_cnt until out_valid rises, checking every cycle.
  // Pulses in_valid during RUN; those samples must be ignored.
  task automatic run_frame(input string tag, input bit toggle, input logic [5:0] start_cnt,
                           output int en_cnt, output int run_cyc);
    logic [5:0] exp_cnt;
    logic       ce;
    int         cyc;
    exp_cnt = start_cnt;
    en_cnt  = 0;
    cyc     = 0;
    while (cyc < 300) begin
      ce = toggle ? ((cyc % 2) == 0) : 1'b1;
      drive(ce, (cyc % 7) == 3, 1'b0);
      #1;
      if (bus.out_valid) break;
      check_vec(tag, pack(1'b0, 1'b1, 1'b0, (exp_cnt == 6'd0) && ce, ce, exp_cnt));
      if (ce) begin
        en_cnt++;
        exp_cnt = exp_cnt + 6'd1;
      end
      cyc++;
      @(negedge clk);
    end
    run_cyc = cyc;
    check_val({tag, "_done"}, int'(bus.out_valid), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en_cnt;
    int run_cyc;

    tbl[0] = '{1'b0, 1'b1, 1'b0, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0)};
    tbl[1] = '{1'b1, 1'b0, 1'b1, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0)};
    tbl[2] = '{1'b0, 1'b1, 1'b0, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0)};
    tbl[3] = '{1'b0, 1'b0, 1'b0, pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0)};
    tbl[4] = '{1'b1, 1'b1, 1'b0, pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd0)};
    tbl[5] = '{1'b0, 1'b1, 1'b0, pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1)};
    tbl[6] = '{1'b1, 1'b0, 1'b0, pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd1)};
    tbl[7] = '{1'b1, 1'b1, 1'b0, pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd2)};

    reset_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check_vec("reset_0", pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
    @(negedge clk);
    check_vec("reset_1", pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].ce, tbl[i].iv, tbl[i].ordy);
      #1;
      check_vec($sformatf("vec_%0d", i), tbl[i].want);
      @(negedge clk);
    end

    run_frame("frame_a", 1'b0, 6'd3, en_cnt, run_cyc);
    check_val("frame_a_enables", en_cnt, 61);
    check_val("frame_a_cycles", run_cyc, 61);

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      #1;
      check_vec("hold_backpressure", pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0));
      @(negedge clk);
    end

    drive(1'b1, 1'b1, 1'b1);
    #1;
    check_vec("hold_b2b_accept", pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0));
    @(negedge clk);

    run_frame("frame_stall", 1'b1, 6'd0, en_cnt, run_cyc);
    check_val("frame_stall_enables", en_cnt, 64);
    check_val("frame_stall_cycles", run_cyc, 127);

    drive(1'b0, 1'b0, 1'b1);
    #1;
    check_val("release_out_valid", int'(bus.out_valid), 1);
    check_val("release_busy", int'(bus.busy), 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    check_vec("idle_after_release", pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
    @(negedge clk);

    drive(1'b1, 1'b1, 1'b0);
    #1;
    check_vec("accept_before_reset", pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
    @(negedge clk);

    for (int i = 0; i <= 30; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      #1;
      check_vec("mid_run", pack(1'b0, 1'b1, 1'b0, i == 0, 1'b1, 6'(i)));
      if (i < 30) @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    check_vec("mid_reset_async", pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
    @(negedge clk);
    check_vec("mid_reset_hold", pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    #1;
    check_vec("post_reset_pre_edge", pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0);
    #1;
    check_vec("post_reset_idle", pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
    @(negedge clk);

    run_frame("frame_after_reset", 1'b0, 6'd0, en_cnt, run_cyc);
    check_val("frame_after_reset_enables", en_cnt, 64);
    check_val("frame_after_reset_cycles", run_cyc, 64);

    drive(1'b0, 1'b0, 1'b1);
    #1;
    check_vec("final_hold", pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0));
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    check_vec("final_idle", pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
